// File: rtl/cla_seq_adder_pkg.sv
// Shared types and sizing helpers for the sequential CLA adder.
// Build option: CLA_SEQ_SUB_EN adds the in_op subtract path in cla_seq_adder.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_num_slices(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice counter width; never narrower than one bit so SLICE==WIDTH still elaborates.
  function automatic int calc_idx_w(input int width, input int slice);
    int n;
    n = width / slice;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_slice.sv
// Combinational SLICE-bit carry-lookahead adder with group propagate/generate.
// Build option: none (CLA_SEQ_SUB_EN only affects cla_seq_adder).
module cla_slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] sum,
  output logic             c_out,
  output logic             grp_p,
  output logic             grp_g
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   carry;

  // Carry into bit n, flattened: g[n-1] | p[n-1]g[n-2] | ... | p[n-1:0]cin.
  function automatic logic la_carry(input logic [SLICE-1:0] gv, input logic [SLICE-1:0] pv,
                                    input logic cin, input int n);
    logic c;
    logic run_p;
    c     = 1'b0;
    run_p = 1'b1;
    for (int j = SLICE - 1; j >= 0; j--) begin
      if (j < n) begin
        c     = c | (run_p & gv[j]);
        run_p = run_p & pv[j];
      end
    end
    return c | (run_p & cin);
  endfunction

  assign p = a | b;
  assign g = a & b;

  always_comb begin
    carry    = '0;
    carry[0] = c_in;
    for (int i = 1; i <= SLICE; i++) begin
      carry[i] = la_carry(g, p, c_in, i);
    end
  end

  assign sum   = a ^ b ^ carry[SLICE-1:0];
  assign c_out = carry[SLICE];
  assign grp_p = &p;
  assign grp_g = la_carry(g, p, 1'b0, SLICE);

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that reuses one SLICE-bit CLA slice over WIDTH/SLICE cycles, LSB slice first.
// Build option: define CLA_SEQ_SUB_EN to add the in_op port (1 = a - b).
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one slice added per cycle, carry held in carry_q
// DONE  | result presented until out_ready
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c_in,
`ifdef CLA_SEQ_SUB_EN
  input  logic             in_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c_out,
  output logic             busy
);

  localparam int NUM_SLICES = calc_num_slices(WIDTH, SLICE);
  localparam int IDX_W      = calc_idx_w(WIDTH, SLICE);

  if ((WIDTH % SLICE) != 0 || SLICE < 1 || SLICE > WIDTH) begin : g_bad_cfg
    $error("cla_seq_adder: WIDTH must be a positive multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic [SLICE-1:0] slice_sum;
  logic             slice_c_out;
  logic             slice_p;
  logic             slice_g;
  logic             last_slice;

  cla_slice_adder #(.SLICE(SLICE)) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_c_out),
    .grp_p (slice_p),
    .grp_g (slice_g)
  );

  assign last_slice = (idx_q == IDX_W'(NUM_SLICES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_c_in;
          idx_d   = '0;
`ifdef CLA_SEQ_SUB_EN
          // Two's complement: a + ~b + 1.
          if (in_op == OP_SUB) begin
            b_d     = ~in_b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = slice_c_out;
        sum_d   = WIDTH'({slice_sum, sum_q} >> SLICE);
        idx_d   = last_slice ? '0 : idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_s     = sum_q;
  assign out_c_out = carry_q;

  // Ripple carry-out and block lookahead carry must agree.
  a_grp_carry : assert property (@(posedge clock) disable iff (!reset)
    slice_c_out == (slice_g | (slice_p & carry_q)));

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=32, SLICE=4); subtract vectors when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        op;
    logic [31:0] exp_s;
    logic        exp_c;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_c_in;
`ifdef CLA_SEQ_SUB_EN
  logic        in_op;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_c_out;
  logic        busy;

  int n_vec;
  int n_err;
  vec_t vecs[$];

  cla_seq_adder #(.WIDTH(32), .SLICE(4)) dut (
    .clock     (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c_in   (in_c_in),
`ifdef CLA_SEQ_SUB_EN
    .in_op     (in_op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c_out (out_c_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic op);
    in_a     = a;
    in_b     = b;
    in_c_in  = cin;
`ifdef CLA_SEQ_SUB_EN
    in_op    = op;
`else
    if (op) $display("note: op ignored in add-only build");
`endif
    in_valid = 1'b1;
  endtask

  // Present a request and return once it is accepted (edge E0 + 1 time unit).
  task automatic accept_req(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic op);
    drive_req(a, b, cin, op);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic op,
                       output logic [31:0] s, output logic c, output int lat);
    accept_req(a, b, cin, op);
    wait_result(lat);
    s = out_s;
    c = out_c_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  initial begin
    logic [31:0] s;
    logic        c;
    int          lat;
    logic [31:0] held_s;
    logic        held_c;
    logic        seen;
    int          acc_cyc[2];
    int          n_acc;
    logic [31:0] res[2];
    int          n_res;
    logic        acc;

    n_vec = 0;
    n_err = 0;

    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0});
    vecs.push_back('{32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 32'hEFBE_D000, 1'b0});
`ifdef CLA_SEQ_SUB_EN
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1});
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1});
`endif

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c_in   = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    in_op     = 1'b0;
`endif
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_out_c_out", out_c_out, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, s, c, lat);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].exp_s);
      chk($sformatf("vec%0d_cout", i), c, vecs[i].exp_c);
      chk($sformatf("vec%0d_latency", i), lat, 8);
    end

    // Backpressure: result must hold while out_ready stays low.
    accept_req(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);
    wait_result(lat);
    chk("bp_latency", lat, 8);
    held_s = out_s;
    held_c = out_c_out;
    chk("bp_sum", held_s, 32'h9999_9999);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_s", out_s, 32'h9999_9999);
      chk("bp_out_c_out", out_c_out, held_c);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);

    // Reset three cycles into a run aborts it.
    accept_req(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_s", out_s, 0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    drive_req(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    n_acc = 0;
    n_res = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    res[0] = '0;
    res[1] = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) drive_req(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        else in_valid = 1'b0;
      end
      if (out_valid && n_res < 2) begin
        res[n_res] = out_s;
        n_res++;
      end
      if (n_res == 2) break;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_accept_spacing", acc_cyc[1] - acc_cyc[0], 10);
    chk("b2b_results", n_res, 2);
    chk("b2b_sum0", res[0], 32'h0000_0003);
    chk("b2b_sum1", res[1], 32'h0000_0030);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
